// File: rtl/io_port_bank.sv
// Memory-mapped I/O port bank: output registers with write strobes, synchronised
// inputs, per-port change flags (write-1-to-clear) and a maskable interrupt.
module io_port_bank #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int N_PORTS     = 16,
  parameter int OUT_BASE    = 'hE0,
  parameter int IN_BASE     = 'hF0,
  parameter int CTL_BASE    = 'hD0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        CLK,
  input  logic                        RST_L,
  input  logic [ADDR_W-1:0]           ADDRESS,
  input  logic [DATA_W-1:0]           DIN,
  input  logic                        EN_WRITE,
  output logic [DATA_W-1:0]           DOUT,
  input  logic [N_PORTS*DATA_W-1:0]   PORT_IN,
  output logic [N_PORTS*DATA_W-1:0]   PORT_OUT,
  output logic [N_PORTS-1:0]          OUT_STB,
  output logic                        IRQ
);
  localparam int NB = (N_PORTS + DATA_W - 1) / DATA_W;
  localparam int VW = NB * DATA_W;
  localparam int PW = N_PORTS * DATA_W;
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [VW-1:0] VALID = VW'({N_PORTS{1'b1}});

  function automatic bit spans_overlap(int a, int la, int b, int lb);
    return (a < b + lb) && (b < a + la);
  endfunction

  localparam bit CFG_BAD = (N_PORTS < 1) || (N_PORTS > 32) || (SYNC_STAGES < 2) ||
    spans_overlap(OUT_BASE, N_PORTS, IN_BASE, N_PORTS) ||
    spans_overlap(OUT_BASE, N_PORTS, CTL_BASE, 2 * NB) ||
    spans_overlap(IN_BASE, N_PORTS, CTL_BASE, 2 * NB);

  if (CFG_BAD) begin : g_cfg_check
    $fatal(1, "io_port_bank: bad configuration or overlapping address regions");
  end

  logic [PW-1:0]     sync_p [SYNC_STAGES];
  logic [PW-1:0]     prev_q;
  logic [VW-1:0]     flag_q;
  logic [VW-1:0]     mask_q;
  logic [CW-1:0]     arm_q;

  logic [PW-1:0]     sync_w;
  logic [VW-1:0]     chg_w;
  logic [VW-1:0]     set_w;
  logic [VW-1:0]     clr_w;
  logic [VW-1:0]     flag_d;
  logic [VW-1:0]     mask_d;
  logic [PW-1:0]     out_d;
  logic [N_PORTS-1:0] stb_d;
  logic [DATA_W-1:0] rd_d;
  int                addr_i;

  assign sync_w = sync_p[SYNC_STAGES-1];
  assign addr_i = int'(ADDRESS);

  always_comb begin
    chg_w = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      chg_w[k] = |(sync_w[k*DATA_W +: DATA_W] ^ prev_q[k*DATA_W +: DATA_W]);
    end
  end

  // Flags only arm once the synchronisers hold post-reset input data.
  assign set_w  = (arm_q == '0) ? chg_w : '0;
  assign flag_d = ((flag_q & ~clr_w) | set_w) & VALID;

  always_comb begin
    out_d  = PORT_OUT;
    stb_d  = '0;
    clr_w  = '0;
    mask_d = mask_q;
    rd_d   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (addr_i == OUT_BASE + k) begin
        rd_d = PORT_OUT[k*DATA_W +: DATA_W];
        if (EN_WRITE) begin
          out_d[k*DATA_W +: DATA_W] = DIN;
          stb_d[k] = 1'b1;
        end
      end
      if (addr_i == IN_BASE + k) begin
        rd_d = sync_w[k*DATA_W +: DATA_W];
      end
    end
    for (int j = 0; j < NB; j++) begin
      if (addr_i == CTL_BASE + j) begin
        rd_d = flag_q[j*DATA_W +: DATA_W];
        if (EN_WRITE) clr_w[j*DATA_W +: DATA_W] = DIN;
      end
      if (addr_i == CTL_BASE + NB + j) begin
        rd_d = mask_q[j*DATA_W +: DATA_W];
        if (EN_WRITE) mask_d[j*DATA_W +: DATA_W] = DIN;
      end
    end
    mask_d = mask_d & VALID;
  end

  // Register stage: synchronisers, change history, bus-visible state.
  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
      prev_q   <= '0;
      flag_q   <= '0;
      mask_q   <= '0;
      arm_q    <= CW'(SYNC_STAGES + 1);
      PORT_OUT <= '0;
      OUT_STB  <= '0;
      DOUT     <= '0;
      IRQ      <= 1'b0;
    end else begin
      sync_p[0] <= PORT_IN;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
      prev_q <= sync_w;
      if (arm_q != '0) arm_q <= arm_q - CW'(1);
      flag_q   <= flag_d;
      mask_q   <= mask_d;
      PORT_OUT <= out_d;
      OUT_STB  <= stb_d;
      DOUT     <= rd_d;
      IRQ      <= |(flag_q & mask_q);
    end
  end
endmodule
